// File: rtl/alu_issue_controller_pkg.sv
// rtl/alu_issue_controller_pkg.sv - shared sizes, FSM encoding and pipeline stage type
package alu_issue_controller_pkg;

   localparam int NUM_REGS        = 16;
   localparam int REG_W           = 4;
   localparam int OP_W            = 3;
   localparam int DEFAULT_LATENCY = 3;
   localparam int NUM_CHECKS      = 6;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   typedef struct packed {
      logic             valid;
      logic             we1;
      logic [REG_W-1:0] sel1;
      logic             we2;
      logic [REG_W-1:0] sel2;
   } wb_stage_t;

endpackage

// File: rtl/alu_scoreboard.sv
// rtl/alu_scoreboard.sv - pending-write bits with retire bypass and set-over-clear priority
module alu_scoreboard
   import alu_issue_controller_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             set_en1,
   input  logic [REG_W-1:0]                 set_sel1,
   input  logic                             set_en2,
   input  logic [REG_W-1:0]                 set_sel2,
   input  logic                             clr_en1,
   input  logic [REG_W-1:0]                 clr_sel1,
   input  logic                             clr_en2,
   input  logic [REG_W-1:0]                 clr_sel2,
   input  logic [NUM_CHECKS-1:0]            chk_en,
   input  logic [NUM_CHECKS-1:0][REG_W-1:0] chk_sel,
   output logic [NUM_REGS-1:0]              busy_mask,
   output logic                             hazard
);

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] busy_bypass;
   logic [NUM_REGS-1:0] busy_next;

   // Lookups see this cycle's retirements already cleared; r0 is forced idle.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en1) set_mask[set_sel1] = 1'b1;
      if (set_en2) set_mask[set_sel2] = 1'b1;
      if (clr_en1) clr_mask[clr_sel1] = 1'b1;
      if (clr_en2) clr_mask[clr_sel2] = 1'b1;
      busy_bypass    = busy_mask & ~clr_mask;
      busy_bypass[0] = 1'b0;
      busy_next      = busy_bypass | set_mask;
      busy_next[0]   = 1'b0;
      hazard         = 1'b0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
         if (chk_en[i] && busy_bypass[chk_sel[i]]) hazard = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) busy_mask <= '0;
      else     busy_mask <= busy_next;
   end

endmodule

// File: rtl/alu_issue_controller.sv
// rtl/alu_issue_controller.sv - ALU issue gate with scoreboard, writeback pipeline and flush drain
module alu_issue_controller
   import alu_issue_controller_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_W-1:0]     alu_op,
   input  logic                const_c,
   input  logic [1:0]          alu_write,
   input  logic [REG_W-1:0]    alu_a_select,
   input  logic [REG_W-1:0]    alu_b_select,
   input  logic [REG_W-1:0]    alu_c_select,
   input  logic [REG_W-1:0]    alu_d_select,
   input  logic [REG_W-1:0]    alu_Y1_select,
   input  logic [REG_W-1:0]    alu_Y2_select,
   input  logic                flush_req,
   output logic                issue_valid,
   output logic [OP_W-1:0]     issue_op,
   output logic                wb_en1,
   output logic                wb_en2,
   output logic [REG_W-1:0]    wb_sel1,
   output logic [REG_W-1:0]    wb_sel2,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic [3:0]          inflight,
   output logic                drained
);

   state_t    state;
   wb_stage_t pipe [LATENCY];
   wb_stage_t entry;
   wb_stage_t tail;
   logic      hazard;
   logic      issue;
   logic      retire;
   logic      keep_y2;
   logic [3:0] inflight_next;

   assign in_ready    = (state == RUN) && !hazard;
   assign issue       = in_valid && in_ready;
   assign issue_valid = issue;
   assign issue_op    = issue ? alu_op : '0;

   // A doubled destination keeps only the Y1 write.
   assign keep_y2 = alu_write[1] && !(alu_write[0] && (alu_Y1_select == alu_Y2_select));
   assign entry   = '{valid: issue, we1: issue && alu_write[0], sel1: alu_Y1_select,
                      we2: issue && keep_y2, sel2: alu_Y2_select};

   assign tail    = pipe[LATENCY-1];
   assign retire  = tail.valid;
   assign wb_en1  = tail.we1;
   assign wb_en2  = tail.we2;
   assign wb_sel1 = tail.we1 ? tail.sel1 : '0;
   assign wb_sel2 = tail.we2 ? tail.sel2 : '0;

   assign inflight_next = inflight + {3'b000, issue} - {3'b000, retire};
   assign drained       = (state == DRAIN) && (inflight_next == 4'd0);

   alu_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en1  (entry.we1),
      .set_sel1 (entry.sel1),
      .set_en2  (entry.we2),
      .set_sel2 (entry.sel2),
      .clr_en1  (tail.we1),
      .clr_sel1 (tail.sel1),
      .clr_en2  (tail.we2),
      .clr_sel2 (tail.sel2),
      .chk_en   ({alu_write[1], alu_write[0], !const_c, !const_c, 1'b1, 1'b1}),
      .chk_sel  ({alu_Y2_select, alu_Y1_select, alu_d_select, alu_c_select,
                  alu_b_select, alu_a_select}),
      .busy_mask(busy_mask),
      .hazard   (hazard)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= entry;
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         inflight <= 4'd0;
      end else begin
         inflight <= inflight_next;
         case (state)
            RUN:     if (flush_req) state <= DRAIN;
            DRAIN:   if (inflight_next == 4'd0) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_controller.sv
// tb/tb_alu_issue_controller.sv - vector table, reset sequence and random run against a queue model
module tb_alu_issue_controller;

   localparam int L = 3;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, const_c, flush_req;
   logic        issue_valid, wb_en1, wb_en2, drained;
   logic [2:0]  alu_op, issue_op;
   logic [1:0]  alu_write;
   logic [3:0]  a_sel, b_sel, c_sel, d_sel, y1_sel, y2_sel, wb_sel1, wb_sel2, inflight;
   logic [15:0] busy_mask;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   alu_issue_controller #(.LATENCY(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
      .const_c(const_c), .alu_write(alu_write), .alu_a_select(a_sel), .alu_b_select(b_sel),
      .alu_c_select(c_sel), .alu_d_select(d_sel), .alu_Y1_select(y1_sel),
      .alu_Y2_select(y2_sel), .flush_req(flush_req), .issue_valid(issue_valid),
      .issue_op(issue_op), .wb_en1(wb_en1), .wb_en2(wb_en2), .wb_sel1(wb_sel1),
      .wb_sel2(wb_sel2), .busy_mask(busy_mask), .inflight(inflight), .drained(drained)
   );

   typedef struct {
      logic rst, val, fl, cc;
      logic [2:0] op;
      logic [1:0] wr;
      logic [3:0] a, b, c, d, y1, y2;
      logic rdy, iss, w1, w2, drn;
      logic [3:0] s1, s2, inf;
      logic [15:0] busy;
   } vec_t;

   vec_t tv[$];

   typedef struct {
      int t;
      bit we1;
      bit [3:0] s1;
      bit we2;
      bit [3:0] s2;
   } op_t;

   op_t q[$];
   bit  m_drain;

   function automatic vec_t vec(input logic r, v, f, input logic [2:0] op, input logic cc,
                                input logic [1:0] wr, input logic [3:0] a, b, c, d, y1, y2,
                                input logic rdy, iss, w1, input logic [3:0] s1, input logic w2,
                                input logic [3:0] s2, input logic [15:0] busy,
                                input logic [3:0] inf, input logic drn);
      vec_t x;
      x.rst = r; x.val = v; x.fl = f; x.op = op; x.cc = cc; x.wr = wr;
      x.a = a; x.b = b; x.c = c; x.d = d; x.y1 = y1; x.y2 = y2;
      x.rdy = rdy; x.iss = iss; x.w1 = w1; x.s1 = s1; x.w2 = w2; x.s2 = s2;
      x.busy = busy; x.inf = inf; x.drn = drn;
      return x;
   endfunction

   function automatic vec_t idle(input logic r, rdy, w1, input logic [3:0] s1,
                                 input logic [15:0] busy, input logic [3:0] inf, input logic drn);
      return vec(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, w1, s1, 0, 0, busy, inf, drn);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      rst = x.rst; in_valid = x.val; flush_req = x.fl; alu_op = x.op; const_c = x.cc;
      alu_write = x.wr; a_sel = x.a; b_sel = x.b; c_sel = x.c; d_sel = x.d;
      y1_sel = x.y1; y2_sel = x.y2;
   endtask

   task automatic build_table();
      // basic issue, RAW stall released by retire bypass
      tv.push_back(vec(0,1,0, 5,0,3, 1,2,3,4, 1,3, 1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(vec(0,1,0, 2,1,0, 3,0,0,0, 0,0, 0,0, 0,0,0,0, 16'h000A,1,0));
      tv.push_back(vec(0,1,0, 2,1,0, 3,0,0,0, 0,0, 0,0, 0,0,0,0, 16'h000A,1,0));
      tv.push_back(vec(0,1,0, 2,1,0, 3,0,0,0, 0,0, 1,1, 1,1,1,3, 16'h000A,1,0));
      tv.push_back(idle(0,1,0,0, 16'h0000,1,0));
      tv.push_back(idle(0,1,0,0, 16'h0000,1,0));
      tv.push_back(idle(0,1,0,0, 16'h0000,1,0));
      tv.push_back(idle(0,1,0,0, 16'h0000,0,0));
      // constant form, r0 destination and r0 sources
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 3,0, 1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(vec(0,1,0, 4,1,1, 0,0,3,3, 0,0, 1,1, 0,0,0,0, 16'h0008,1,0));
      tv.push_back(vec(0,1,0, 3,0,0, 0,0,0,0, 0,0, 1,1, 0,0,0,0, 16'h0008,2,0));
      tv.push_back(idle(0,1,1,3,  16'h0008,3,0));
      tv.push_back(idle(0,1,1,0,  16'h0000,2,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,1,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
      // Y1=Y2 dedupe, WAW stall, set beats clear
      tv.push_back(vec(0,1,0, 7,1,3, 0,0,0,0, 5,5, 1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(vec(0,1,0, 6,1,1, 0,0,0,0, 5,0, 0,0, 0,0,0,0, 16'h0020,1,0));
      tv.push_back(vec(0,1,0, 6,1,1, 0,0,0,0, 5,0, 0,0, 0,0,0,0, 16'h0020,1,0));
      tv.push_back(vec(0,1,0, 6,1,1, 0,0,0,0, 5,0, 1,1, 1,5,0,0, 16'h0020,1,0));
      tv.push_back(idle(0,1,0,0,  16'h0020,1,0));
      tv.push_back(idle(0,1,0,0,  16'h0020,1,0));
      tv.push_back(idle(0,1,1,5,  16'h0020,1,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
      // back-to-back
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 6,0, 1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(vec(0,1,0, 2,1,1, 0,0,0,0, 7,0, 1,1, 0,0,0,0, 16'h0040,1,0));
      tv.push_back(vec(0,1,0, 3,1,1, 0,0,0,0, 8,0, 1,1, 0,0,0,0, 16'h00C0,2,0));
      tv.push_back(idle(0,1,1,6,  16'h01C0,3,0));
      tv.push_back(idle(0,1,1,7,  16'h0180,2,0));
      tv.push_back(idle(0,1,1,8,  16'h0100,1,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
      // flush with two in flight, repeated flush_req in DRAIN
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 9,0,  1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 10,0, 1,1, 0,0,0,0, 16'h0200,1,0));
      tv.push_back(vec(0,0,1, 0,0,0, 0,0,0,0, 0,0,  1,0, 0,0,0,0, 16'h0600,2,0));
      tv.push_back(vec(0,1,1, 1,1,1, 0,0,0,0, 11,0, 0,0, 1,9,0,0, 16'h0600,2,0));
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 11,0, 0,0, 1,10,0,0,16'h0400,1,1));
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 11,0, 1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(idle(0,1,0,0,  16'h0800,1,0));
      tv.push_back(idle(0,1,0,0,  16'h0800,1,0));
      tv.push_back(idle(0,1,1,11, 16'h0800,1,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
      // issue in the same cycle as flush_req
      tv.push_back(vec(0,1,1, 2,1,1, 0,0,0,0, 12,0, 1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(idle(0,0,0,0,  16'h1000,1,0));
      tv.push_back(idle(0,0,0,0,  16'h1000,1,0));
      tv.push_back(idle(0,0,1,12, 16'h1000,1,1));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
      // reset with two in flight
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 13,0, 1,1, 0,0,0,0, 16'h0000,0,0));
      tv.push_back(vec(0,1,0, 1,1,1, 0,0,0,0, 14,0, 1,1, 0,0,0,0, 16'h2000,1,0));
      tv.push_back(idle(1,1,0,0,  16'h6000,2,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
      tv.push_back(idle(0,1,0,0,  16'h0000,0,0));
   endtask

   function automatic logic [15:0] dest_mask(input op_t o);
      logic [15:0] m = '0;
      if (o.we1 && o.s1 != 0) m[o.s1] = 1'b1;
      if (o.we2 && o.s2 != 0) m[o.s2] = 1'b1;
      return m;
   endfunction

   initial begin
      bit          retiring, hazard, rdy_e, iss_e, drn_e;
      int          n_next;
      logic [15:0] busy_e, pend;
      logic [3:0]  regs [6];
      bit          used [6];
      op_t         hd, nw;

      build_table();

      // instruction held on the inputs throughout reset
      drive(vec(1,1,0, 5,0,3, 1,2,3,4, 1,3, 0,0,0,0,0,0, 0,0,0));
      repeat (3) @(negedge clk);
      drive(idle(0,0,0,0,0,0,0));
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_issue_op", issue_op, 0);
      chk("rst_wb_en1", wb_en1, 0);
      chk("rst_wb_en2", wb_en2, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_drained", drained, 0);
      cyc++;

      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i]);
         #1;
         chk($sformatf("tv%0d_ready", i), in_ready, tv[i].rdy);
         chk($sformatf("tv%0d_issue", i), issue_valid, tv[i].iss);
         if (tv[i].iss) chk($sformatf("tv%0d_op", i), issue_op, tv[i].op);
         chk($sformatf("tv%0d_wb_en1", i), wb_en1, tv[i].w1);
         if (tv[i].w1) chk($sformatf("tv%0d_wb_sel1", i), wb_sel1, tv[i].s1);
         chk($sformatf("tv%0d_wb_en2", i), wb_en2, tv[i].w2);
         if (tv[i].w2) chk($sformatf("tv%0d_wb_sel2", i), wb_sel2, tv[i].s2);
         chk($sformatf("tv%0d_busy", i), busy_mask, tv[i].busy);
         chk($sformatf("tv%0d_inflight", i), inflight, tv[i].inf);
         chk($sformatf("tv%0d_drained", i), drained, tv[i].drn);
         cyc++;
      end

      @(negedge clk);
      drive(idle(1,0,0,0,0,0,0));
      cyc++;
      q.delete();
      m_drain = 0;

      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         rst = 0;
         in_valid = ($urandom % 10) < 7;
         flush_req = ($urandom % 25) == 0;
         alu_op = 3'($urandom);
         const_c = 1'($urandom);
         alu_write = 2'($urandom);
         a_sel = 4'($urandom % 6); b_sel = 4'($urandom % 6);
         c_sel = 4'($urandom % 6); d_sel = 4'($urandom % 6);
         y1_sel = 4'($urandom % 6); y2_sel = 4'($urandom % 6);
         #1;

         retiring = (q.size() > 0) && (cyc - q[0].t == L);
         busy_e = '0;
         pend = '0;
         foreach (q[k]) begin
            busy_e |= dest_mask(q[k]);
            if (!(retiring && k == 0)) pend |= dest_mask(q[k]);
         end
         regs[0] = a_sel; used[0] = 1;
         regs[1] = b_sel; used[1] = 1;
         regs[2] = c_sel; used[2] = !const_c;
         regs[3] = d_sel; used[3] = !const_c;
         regs[4] = y1_sel; used[4] = alu_write[0];
         regs[5] = y2_sel; used[5] = alu_write[1];
         hazard = 0;
         for (int k = 0; k < 6; k++)
            if (used[k] && regs[k] != 0 && pend[regs[k]]) hazard = 1;
         rdy_e = !m_drain && !hazard;
         iss_e = in_valid && rdy_e;
         n_next = q.size() + int'(iss_e) - int'(retiring);
         drn_e = m_drain && n_next == 0;

         chk("rnd_ready", in_ready, rdy_e);
         chk("rnd_issue", issue_valid, iss_e);
         if (iss_e) chk("rnd_op", issue_op, alu_op);
         if (retiring) begin
            hd = q[0];
            chk("rnd_wb_en1", wb_en1, hd.we1);
            if (hd.we1) chk("rnd_wb_sel1", wb_sel1, hd.s1);
            chk("rnd_wb_en2", wb_en2, hd.we2);
            if (hd.we2) chk("rnd_wb_sel2", wb_sel2, hd.s2);
         end else begin
            chk("rnd_wb_en1", wb_en1, 0);
            chk("rnd_wb_en2", wb_en2, 0);
         end
         chk("rnd_busy", busy_mask, busy_e);
         chk("rnd_inflight", inflight, q.size());
         chk("rnd_drained", drained, drn_e);

         if (retiring) void'(q.pop_front());
         if (iss_e) begin
            nw.t = cyc;
            nw.we1 = alu_write[0]; nw.s1 = y1_sel;
            nw.we2 = alu_write[1] && !(alu_write[0] && y1_sel == y2_sel); nw.s2 = y2_sel;
            q.push_back(nw);
         end
         if (!m_drain && flush_req) m_drain = 1;
         else if (m_drain && n_next == 0) m_drain = 0;
         cyc++;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_controller.md
ALU_ISSUE_CONTROLLER -- requirements
Module: alu_issue_controller

Interface
REQ-001 The block SHALL be parameterised: LATENCY, default 3, ALU cycles from issue to writeback (legal 1..8).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded ALU instruction present.
- in_ready  out  1  controller accepts the instruction this cycle.
- alu_op  in  3  decoded operation.
- const_c  in  1  c/d fields carry a constant, not registers.
- alu_write  in  2  bit0 = write Y1, bit1 = write Y2.
- alu_a_select, alu_b_select, alu_c_select, alu_d_select  in  4 each  source registers.
- alu_Y1_select, alu_Y2_select  in  4 each  destination registers.
- flush_req  in  1  request drain of in-flight operations.
- issue_valid  out  1  one-cycle ALU start strobe.
- issue_op  out  3  operation driven with issue_valid.
- wb_en1, wb_en2  out  1 each  register-file write enables.
- wb_sel1, wb_sel2  out  4 each  register-file write addresses.
- busy_mask  out  16  scoreboard; bit n = register n has a pending write.
- inflight  out  4  number of issued, not yet retired operations.
- drained  out  1  one-cycle pulse when a flush completes.

Function
REQ-003 An instruction SHALL issue in the cycle where in_valid and in_ready are both 1.
- issue_valid=1 and issue_op=alu_op in that same cycle, combinationally.
REQ-004 Sources a and b SHALL always be hazard-checked; c and d SHALL be checked only when const_c=0.
REQ-005 Destinations SHALL be hazard-checked only when their alu_write bit is 1 (WAW check).
REQ-006 Register 0 SHALL never be marked busy and SHALL never raise a hazard.
REQ-007 in_ready SHALL be 1 only when all of the following hold:
- state is RUN;
- no checked register is busy after this cycle's retirement is applied (same-cycle retire bypass).
REQ-008 On issue, the controller SHALL set busy bits for enabled, nonzero destinations.
- If Y1=Y2 and both are enabled, only the Y1 write is kept.
REQ-009 Issued writes SHALL travel through a LATENCY-deep shift pipeline.
- Each stage holds {valid, we1, sel1, we2, sel2}.
- Writeback asserts exactly LATENCY cycles after issue.
- Throughput: one issue per cycle.
REQ-010 At writeback, the controller SHALL do all of the following in that cycle:
- assert wb_en1/wb_en2 with their wb_sel1/wb_sel2;
- clear the matching busy bits.
REQ-011 If a busy bit is both cleared (retire) and set (issue) in one cycle, the set SHALL win.
REQ-012 inflight SHALL update by +1 on issue and −1 on retire; an issue and a retire in the same cycle leave it unchanged.
REQ-013 The FSM SHALL have two states, RUN and DRAIN.
- RUN → DRAIN when flush_req=1.
- DRAIN → RUN when inflight=0, after the update of REQ-012 has been applied; drained pulses 1 in that transition cycle.
- flush_req while already in DRAIN is ignored.
REQ-014 An instruction presented in the same cycle that flush_req is sampled in RUN SHALL still issue if in_ready=1.
- in_ready is evaluated on the current state.

Reset
REQ-015 While rst=1 at a clock edge, the controller SHALL reset:
- state to RUN;
- busy_mask to 0, inflight to 0, and all pipeline valid bits to 0.
REQ-016 Reset SHALL discard in-flight operations without writeback.
- The cycle after reset, all outputs are 0, except in_ready, which follows REQ-007.
- Outputs stay 0 for that cycle even if in_valid was held 1 during reset.

Structure
REQ-017 A shared package/header SHALL hold:
- NUM_REGS=16, REG_W=4, OP_W=3, the default LATENCY;
- the RUN/DRAIN state encoding.
REQ-018 The scoreboard (busy bits, set/clear priority, hazard lookup with retire bypass) SHALL be one sub-module, alu_scoreboard.

Verification (LATENCY=3)
REQ-019 The bench SHALL cover these directed scenarios:
- Basic issue: a=1,b=2,c=3,d=4, const_c=0, alu_write=11, Y1=1, Y2=3 → issue at cycle t; busy_mask=0x000A at t+1; wb_en1/wb_en2 with sel 1/3 at t+3; busy_mask=0 at t+4.
- RAW stall: then a=3 at t+1 → in_ready=0 at t+1..t+2; issues at t+3 via retire bypass.
- Constant form: const_c=1, c=d=0 with r0 check, c=3 busy → no stall; alu_write=01, Y1=0 → no busy bit set; wb_en1=1 with wb_sel1=0 at t+3.
- Back-to-back: three independent instructions in consecutive cycles → inflight 1,2,3 then 3,2,1,0; writebacks on three consecutive cycles.
- Flush: flush_req with 2 in flight → in_ready=0; drained pulses exactly once when the last one retires; RUN the next cycle.
- Reset mid-operation: rst with 2 in flight → no wb_en ever; busy_mask=0 and inflight=0 the next cycle.
